hp_alarm_mon: RTL and testbench
===============================

Name: hp_alarm_mon

Overview:
- Monitor stage downstream of the hoggephase glitch detectors.
- Gates the VCC enable that starts the sensor ring oscillators, then blanks alarms during oscillator warm-up.
- Filters the per-channel Alarm outputs by a consecutive-cycle threshold and counts glitch events.
- Latches a sticky trip with per-channel source capture until software clears it.

Parameters:
- N_CH, 4, number of detector channels (INVERT=0 and INVERT=1 instances are counted separately)
- BLANK_CYC, 8, warm-up cycles after VCC_EN rises before alarms are honoured; must be >=1
- THRESH, 2, consecutive sampled-high cycles needed to trip a channel; must be >=1
- CNT_W, 8, width of the event counter

Ports:
- CK  input  1  clock, shared with the detectors
- RST_N  input  1  reset, asynchronous, active-low
- ALARM_IN  input  N_CH  Alarm outputs of the detector instances
- MASK  input  N_CH  1 = ignore that channel
- ARM  input  1  level request to run the monitor
- CLEAR  input  1  single-cycle pulse; clears the trip and the event counter
- VCC_EN  output  1  drives the detector VCC inputs
- TRIP  output  1  sticky tamper/glitch indication
- TRIP_SRC  output  N_CH  channels that caused the trip
- EVENT_CNT  output  CNT_W  saturating count of glitch events
- STATE  output  2  IDLE=0, WARMUP=1, ARMED=2, TRIPPED=3

Behaviour:
- Reset (RST_N low, asynchronous): STATE=IDLE, VCC_EN=0, TRIP=0, TRIP_SRC=0, EVENT_CNT=0, all internal registers 0.
- Input stage, every cycle: alarm_q <= ALARM_IN & ~MASK; alarm_p <= alarm_q.
- Per-channel run counter, ARMED only:
  - run[i] <= alarm_q[i] ? min(run[i]+1, THRESH) : 0.
  - run[i] is forced to 0 in every other state.
- Trip condition: hit[i] = (STATE==ARMED) & alarm_q[i] & (run[i]==THRESH-1).
- Latency: if ALARM_IN[i] is sampled high at edges e0 .. e0+THRESH-1, TRIP is high after edge e0+THRESH.
- FSM:
  - IDLE: VCC_EN=0. If ARM=1, go to WARMUP and load blank counter = BLANK_CYC-1.
  - WARMUP: VCC_EN=1; counter decrements.
    - ARM=0 → IDLE.
    - Counter==0 → ARMED.
    - Alarms in WARMUP are ignored: no trip, no count.
  - ARMED: VCC_EN=1.
    - If any hit → TRIPPED; TRIP<=1; TRIP_SRC<=hit. All channels that hit on the same edge are captured.
    - Otherwise, ARM=0 → IDLE.
    - A hit takes priority over ARM=0.
  - TRIPPED: VCC_EN=1; TRIP and TRIP_SRC hold; ARM is ignored.
    - CLEAR=1 → TRIP<=0, TRIP_SRC<=0.
    - Next state is WARMUP (blank counter reloaded) if ARM=1, else IDLE.
- Event counter:
  - In ARMED or TRIPPED, EVENT_CNT increments by 1 on any cycle where |(alarm_q & ~alarm_p) is true.
  - Increment is 1 regardless of how many channels rise together.
  - Saturates at 2^CNT_W-1; no wrap.
- CLEAR:
  - In any state, CLEAR zeroes EVENT_CNT.
  - If a rising event occurs in the same cycle, EVENT_CNT becomes 1.
  - CLEAR in IDLE, WARMUP or ARMED does not change the FSM.
  - CLEAR coincident with a hit in ARMED: the trip wins and is latched; EVENT_CNT still follows the rule above.
- MASK change: takes effect via alarm_q on the next edge. A masked channel's run counter drops to 0.
- Reset mid-operation: immediately returns to the reset values above; VCC_EN drops asynchronously.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, ARM=1, ALARM_IN=0, BLANK_CYC=8 → VCC_EN=1 after edge 1, STATE=ARMED after edge 9; TRIP stays 0.
- In ARMED, THRESH=2, ALARM_IN[2] high for exactly 1 cycle → no trip, EVENT_CNT=1. Then high for 2 cycles → TRIP=1 two edges after the first sampled-high edge, TRIP_SRC=4'b0100.
- ALARM_IN=4'b1111 held high during WARMUP → no trip, EVENT_CNT=0. Held into ARMED → trip with TRIP_SRC=4'b1111 (the alarm_q stays high through the WARMUP→ARMED edge, so run counts from the first ARMED cycle).
- MASK=4'b0001, ALARM_IN[0] held high 10 cycles → no trip, EVENT_CNT=0. ALARM_IN[1] held 2 cycles → TRIP_SRC=4'b0010.
- TRIPPED then CLEAR pulse with ARM=1 → TRIP=0, STATE=WARMUP, EVENT_CNT=0. Same with ARM=0 → STATE=IDLE, VCC_EN=0.
- CNT_W=4, 20 isolated single-cycle alarm pulses in ARMED with THRESH=4 → EVENT_CNT saturates at 15. Assert RST_N low mid-run → all outputs 0 without waiting for a CK edge.

Source files
------------

// File: rtl/hp_alarm_mon.sv
// hp_alarm_mon: powers the hoggephase detectors, blanks their warm-up,
// filters channel alarms and latches a sticky trip with source capture.
module hp_alarm_mon #(
  parameter int N_CH      = 4,
  parameter int BLANK_CYC = 8,
  parameter int THRESH    = 2,
  parameter int CNT_W     = 8
) (
  input  logic             CK,
  input  logic             RST_N,
  input  logic [N_CH-1:0]  ALARM_IN,
  input  logic [N_CH-1:0]  MASK,
  input  logic             ARM,
  input  logic             CLEAR,
  output logic             VCC_EN,
  output logic             TRIP,
  output logic [N_CH-1:0]  TRIP_SRC,
  output logic [CNT_W-1:0] EVENT_CNT,
  output logic [1:0]       STATE
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    ARMED   = 2'd2,
    TRIPPED = 2'd3
  } st_e;

  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int RW = $clog2(THRESH + 1);
  localparam logic [BW-1:0] BLOAD = BW'(BLANK_CYC - 1);
  localparam logic [RW-1:0] RMAX  = RW'(THRESH);
  localparam logic [RW-1:0] RHIT  = RW'(THRESH - 1);

  st_e             st;
  logic [BW-1:0]   blank;
  logic [N_CH-1:0] aq;
  logic [N_CH-1:0] ap;
  logic [N_CH-1:0] hit;
  logic [RW-1:0]   run [N_CH];
  logic            ev;

  assign STATE = st;

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      hit[i] = (st == ARMED) && aq[i] && (run[i] == RHIT);
    end
  end

  // one event per rising cycle, however many channels rise together
  assign ev = ((st == ARMED) || (st == TRIPPED)) && |(aq & ~ap);

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      aq <= '0;
      ap <= '0;
      for (int i = 0; i < N_CH; i++) run[i] <= '0;
    end else begin
      aq <= ALARM_IN & ~MASK;
      ap <= aq;
      for (int i = 0; i < N_CH; i++) begin
        if ((st == ARMED) && aq[i])
          run[i] <= (run[i] == RMAX) ? RMAX : run[i] + 1'b1;
        else
          run[i] <= '0;
      end
    end
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      EVENT_CNT <= '0;
    end else if (CLEAR) begin
      EVENT_CNT <= CNT_W'(ev);
    end else if (ev && (EVENT_CNT != '1)) begin
      EVENT_CNT <= EVENT_CNT + 1'b1;
    end
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      st       <= IDLE;
      blank    <= '0;
      VCC_EN   <= 1'b0;
      TRIP     <= 1'b0;
      TRIP_SRC <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          VCC_EN <= 1'b0;
          if (ARM) begin
            st     <= WARMUP;
            blank  <= BLOAD;
            VCC_EN <= 1'b1;
          end
        end
        WARMUP: begin
          if (!ARM) begin
            st     <= IDLE;
            VCC_EN <= 1'b0;
          end else if (blank == '0) begin
            st <= ARMED;
          end else begin
            blank <= blank - 1'b1;
          end
        end
        ARMED: begin
          if (|hit) begin
            st       <= TRIPPED;
            TRIP     <= 1'b1;
            TRIP_SRC <= hit;
          end else if (!ARM) begin
            st     <= IDLE;
            VCC_EN <= 1'b0;
          end
        end
        TRIPPED: begin
          if (CLEAR) begin
            TRIP     <= 1'b0;
            TRIP_SRC <= '0;
            if (ARM) begin
              st    <= WARMUP;
              blank <= BLOAD;
            end else begin
              st     <= IDLE;
              VCC_EN <= 1'b0;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hp_alarm_mon.sv
// tb_hp_alarm_mon: table-driven cycle vectors with a scoreboard queue,
// plus counter saturation and asynchronous reset sequences.
module tb_hp_alarm_mon;

  typedef struct {
    logic       arm;
    logic       clr;
    logic [3:0] mask;
    logic [3:0] alarm;
    logic       vcc;
    logic       trip;
    logic [3:0] src;
    logic [7:0] cnt;
    logic [1:0] st;
  } vec_t;

  logic       CK;
  logic       rst_n;
  logic       arm, clr;
  logic [3:0] mask, alarm;
  logic       vcc, trip;
  logic [3:0] src;
  logic [7:0] cnt;
  logic [1:0] st;

  logic       s_arm, s_clr;
  logic [3:0] s_mask, s_alarm;
  logic       s_vcc, s_trip;
  logic [3:0] s_src;
  logic [3:0] s_cnt;
  logic [1:0] s_st;

  int errors = 0;
  int checks = 0;

  vec_t vq[$];
  vec_t sb[$];

  hp_alarm_mon u_dut (
    .CK(CK), .RST_N(rst_n), .ALARM_IN(alarm), .MASK(mask),
    .ARM(arm), .CLEAR(clr), .VCC_EN(vcc), .TRIP(trip),
    .TRIP_SRC(src), .EVENT_CNT(cnt), .STATE(st)
  );

  hp_alarm_mon #(.THRESH(4), .CNT_W(4)) u_sat (
    .CK(CK), .RST_N(rst_n), .ALARM_IN(s_alarm), .MASK(s_mask),
    .ARM(s_arm), .CLEAR(s_clr), .VCC_EN(s_vcc), .TRIP(s_trip),
    .TRIP_SRC(s_src), .EVENT_CNT(s_cnt), .STATE(s_st)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic void add(input int n, input logic a, input logic c,
      input logic [3:0] m, input logic [3:0] al, input logic v,
      input logic t, input logic [3:0] s, input logic [7:0] k,
      input logic [1:0] q);
    vec_t r;
    r.arm = a; r.clr = c; r.mask = m; r.alarm = al;
    r.vcc = v; r.trip = t; r.src = s; r.cnt = k; r.st = q;
    for (int i = 0; i < n; i++) vq.push_back(r);
  endfunction

  task automatic sat_cyc(input logic [3:0] a);
    @(negedge CK);
    s_alarm = a;
    @(posedge CK);
    #1;
  endtask

  initial begin
    vec_t e;
    int   k;
    rst_n = 1'b0;
    arm = 0; clr = 0; mask = 0; alarm = 0;
    s_arm = 0; s_clr = 0; s_mask = 0; s_alarm = 0;

    // arm, warm-up of 8, then single and double pulses on ch2
    add(8, 1,0,4'h0,4'h0, 1,0,4'h0,8'd0,2'd1);
    add(1, 1,0,4'h0,4'h0, 1,0,4'h0,8'd0,2'd2);
    add(1, 1,0,4'h0,4'h4, 1,0,4'h0,8'd0,2'd2);
    add(2, 1,0,4'h0,4'h0, 1,0,4'h0,8'd1,2'd2);
    add(1, 1,0,4'h0,4'h4, 1,0,4'h0,8'd1,2'd2);
    add(1, 1,0,4'h0,4'h4, 1,0,4'h0,8'd2,2'd2);
    add(2, 1,0,4'h0,4'h0, 1,1,4'h4,8'd2,2'd3);
    add(1, 1,1,4'h0,4'h0, 1,0,4'h0,8'd0,2'd1);
    // all channels high through warm-up into armed
    add(7, 1,0,4'h0,4'hf, 1,0,4'h0,8'd0,2'd1);
    add(2, 1,0,4'h0,4'hf, 1,0,4'h0,8'd0,2'd2);
    add(1, 1,0,4'h0,4'hf, 1,1,4'hf,8'd0,2'd3);
    add(1, 0,1,4'h0,4'h0, 0,0,4'h0,8'd0,2'd0);
    // masked ch0, then ch1 trips
    add(8, 1,0,4'h1,4'h0, 1,0,4'h0,8'd0,2'd1);
    add(1, 1,0,4'h1,4'h0, 1,0,4'h0,8'd0,2'd2);
    add(10,1,0,4'h1,4'h1, 1,0,4'h0,8'd0,2'd2);
    add(1, 1,0,4'h1,4'h2, 1,0,4'h0,8'd0,2'd2);
    add(1, 1,0,4'h1,4'h2, 1,0,4'h0,8'd1,2'd2);
    add(1, 1,0,4'h1,4'h0, 1,1,4'h2,8'd1,2'd3);
    add(1, 0,1,4'h1,4'h0, 0,0,4'h0,8'd0,2'd0);
    // clear coincident with hit and with a rising event
    add(8, 1,0,4'h0,4'h0, 1,0,4'h0,8'd0,2'd1);
    add(1, 1,0,4'h0,4'h0, 1,0,4'h0,8'd0,2'd2);
    add(1, 1,0,4'h0,4'h8, 1,0,4'h0,8'd0,2'd2);
    add(1, 1,0,4'h0,4'h9, 1,0,4'h0,8'd1,2'd2);
    add(1, 1,1,4'h0,4'h0, 1,1,4'h8,8'd1,2'd3);
    add(1, 1,0,4'h0,4'h0, 1,1,4'h8,8'd1,2'd3);
    add(1, 0,1,4'h0,4'h0, 0,0,4'h0,8'd0,2'd0);
    // disarm during warm-up and during armed
    add(1, 1,0,4'h0,4'h0, 1,0,4'h0,8'd0,2'd1);
    add(1, 0,0,4'h0,4'h0, 0,0,4'h0,8'd0,2'd0);
    add(8, 1,0,4'h0,4'h0, 1,0,4'h0,8'd0,2'd1);
    add(1, 1,0,4'h0,4'h0, 1,0,4'h0,8'd0,2'd2);
    add(1, 0,0,4'h0,4'h0, 0,0,4'h0,8'd0,2'd0);

    #12;
    chk("rst vcc", {7'd0, vcc}, 8'd0);
    chk("rst trip", {7'd0, trip}, 8'd0);
    chk("rst src", {4'd0, src}, 8'd0);
    chk("rst cnt", cnt, 8'd0);
    chk("rst st", {6'd0, st}, 8'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge CK);
      arm = vq[i].arm; clr = vq[i].clr;
      mask = vq[i].mask; alarm = vq[i].alarm;
      sb.push_back(vq[i]);
      @(posedge CK);
      #1;
      e = sb.pop_front();
      chk($sformatf("row%0d vcc", i), {7'd0, vcc}, {7'd0, e.vcc});
      chk($sformatf("row%0d trip", i), {7'd0, trip}, {7'd0, e.trip});
      chk($sformatf("row%0d src", i), {4'd0, src}, {4'd0, e.src});
      chk($sformatf("row%0d cnt", i), cnt, e.cnt);
      chk($sformatf("row%0d st", i), {6'd0, st}, {6'd0, e.st});
    end
    @(negedge CK);
    arm = 0; clr = 0; alarm = 0; mask = 0;

    // saturation instance: 4-bit counter, isolated single-cycle pulses
    s_arm = 1'b1;
    repeat (9) sat_cyc(4'h0);
    chk("sat armed", {6'd0, s_st}, 8'd2);
    chk("sat vcc", {7'd0, s_vcc}, 8'd1);
    for (int p = 1; p <= 20; p++) begin
      sat_cyc(4'h1);
      sat_cyc(4'h0);
      k = (p > 15) ? 15 : p;
      chk($sformatf("sat cnt p%0d", p), {4'd0, s_cnt}, 8'(k));
    end
    chk("sat notrip", {7'd0, s_trip}, 8'd0);
    chk("sat st", {6'd0, s_st}, 8'd2);

    // asynchronous reset between edges
    @(posedge CK);
    #2 rst_n = 1'b0;
    #1;
    chk("arst vcc", {7'd0, s_vcc}, 8'd0);
    chk("arst cnt", {4'd0, s_cnt}, 8'd0);
    chk("arst st", {6'd0, s_st}, 8'd0);
    chk("arst trip", {7'd0, s_trip}, 8'd0);
    chk("arst src", {4'd0, s_src}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
